// File: rtl/sd_launcher.sv
// Batch launcher for the SD worker: one xs pulse per job, waits for fin, idle gap, per-job watchdog.
// xs one cycle after accepted go; no backpressure: go/fin outside IDLE/WAIT are dropped, not queued.
module sd_launcher #(
    parameter int N_W     = 4,
    parameter int TIMEOUT = 16,
    parameter int GAP     = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           go,
    input  logic [N_W-1:0] njobs,
    input  logic           fin,
    output logic           xs,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [N_W-1:0] completed
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // gap counter only needs to hold 0..GAP-1; keep at least one bit so GAP=0/1 still elaborate
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [N_W-1:0] count, count_nxt;
    logic [N_W-1:0] completed_nxt;
    logic [N_W-1:0] completed_inc;
    logic [TW-1:0]  timer, timer_nxt;
    logic [GW-1:0]  gap_cnt, gap_cnt_nxt;
    logic           err_nxt;

    assign completed_inc = completed + N_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            completed <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            completed <= completed_nxt;
            timer     <= timer_nxt;
            gap_cnt   <= gap_cnt_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        completed_nxt = completed;
        timer_nxt     = timer;
        gap_cnt_nxt   = gap_cnt;
        err_nxt       = err;

        case (state)
            S_IDLE: begin
                if (go) begin
                    count_nxt     = njobs;
                    completed_nxt = '0;
                    err_nxt       = 1'b0;
                    state_nxt     = (njobs == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_nxt = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // fin is checked first so a fin on the expiry edge still counts as success
                if (fin) begin
                    completed_nxt = completed_inc;
                    if (completed_inc == count) begin
                        state_nxt = S_DONE;
                    end else if (GAP == 0) begin
                        state_nxt = S_ISSUE;
                    end else begin
                        gap_cnt_nxt = '0;
                        state_nxt   = S_GAP;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                    if (timer == TIMER_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_ISSUE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign xs   = (state == S_ISSUE);
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    a_xs_single : assert property (@(posedge clk) disable iff (reset) xs |=> !xs);
    a_xs_done   : assert property (@(posedge clk) disable iff (reset) !(xs && done));
    a_cnt_bound : assert property (@(posedge clk) disable iff (reset) completed <= count);

endmodule

// File: tb/tb_sd_launcher.sv
// Scoreboard bench for sd_launcher: stimulus queues expected xs/done events, negedge monitors pop and compare.
module tb_sd_launcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    int         cyc = 0;

    logic       go_a = 1'b0, fin_wa = 1'b0, fin_ma = 1'b0, fin_a;
    logic [3:0] njobs_a = '0, completed_a;
    logic       xs_a, busy_a, done_a, err_a;

    logic       go_b = 1'b0, fin_wb = 1'b0, fin_b;
    logic [3:0] njobs_b = '0, completed_b;
    logic       xs_b, busy_b, done_b, err_b;

    assign fin_a = fin_wa | fin_ma;
    assign fin_b = fin_wb;

    sd_launcher #(.N_W(4), .TIMEOUT(16), .GAP(2)) dut_a (
        .clk(clk), .reset(reset), .go(go_a), .njobs(njobs_a), .fin(fin_a),
        .xs(xs_a), .busy(busy_a), .done(done_a), .err(err_a), .completed(completed_a)
    );

    sd_launcher #(.N_W(4), .TIMEOUT(16), .GAP(0)) dut_b (
        .clk(clk), .reset(reset), .go(go_b), .njobs(njobs_b), .fin(fin_b),
        .xs(xs_b), .busy(busy_b), .done(done_b), .err(err_b), .completed(completed_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 = xs pulse, 1 = done pulse
        int cyc;
        int comp;
        int err;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    ev_t ea, eb;
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected pulse at cycle %0d, none expected", name, cyc);
    endtask

    task automatic cmp_ev(input string p, input ev_t e, input int kind, input int comp, input int err);
        chk({p, " kind"}, kind, e.kind);
        chk({p, " cycle"}, cyc, e.cyc);
        chk({p, " completed"}, comp, e.comp);
        chk({p, " err"}, err, e.err);
    endtask

    function automatic ev_t mk(input int kind, input int c, input int comp, input int err);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.comp = comp;
        e.err  = err;
        return e;
    endfunction

    // monitors
    always @(negedge clk) begin
        if (!reset) begin
            if (xs_a) begin
                if (qa.size() == 0) unexpected("A xs");
                else begin
                    ea = qa.pop_front();
                    cmp_ev("A xs", ea, 0, int'(completed_a), int'(err_a));
                end
            end
            if (done_a) begin
                if (qa.size() == 0) unexpected("A done");
                else begin
                    ea = qa.pop_front();
                    cmp_ev("A done", ea, 1, int'(completed_a), int'(err_a));
                    chk("A busy at done", int'(busy_a), 1);
                end
            end
            if (xs_b) begin
                if (qb.size() == 0) unexpected("B xs");
                else begin
                    eb = qb.pop_front();
                    cmp_ev("B xs", eb, 0, int'(completed_b), int'(err_b));
                end
            end
            if (done_b) begin
                if (qb.size() == 0) unexpected("B done");
                else begin
                    eb = qb.pop_front();
                    cmp_ev("B done", eb, 1, int'(completed_b), int'(err_b));
                    chk("B busy at done", int'(busy_b), 1);
                end
            end
        end
    end

    // worker models: fin is high during the cycle starting dly negedges after xs was seen
    logic [7:0] mask_a = '0, mask_b = '0;
    int dly_a = 3, dly_b = 1;
    int wc_a = 0, jx_a = 0, wc_b = 0, jx_b = 0;

    always @(negedge clk) begin
        fin_wa <= (wc_a == 1);
        if (wc_a > 0) wc_a <= wc_a - 1;
        if (reset || !busy_a) begin
            jx_a <= 0;
            if (reset) wc_a <= 0;
        end else if (xs_a) begin
            if (mask_a[jx_a]) wc_a <= dly_a;
            jx_a <= jx_a + 1;
        end
    end

    always @(negedge clk) begin
        fin_wb <= (wc_b == 1);
        if (wc_b > 0) wc_b <= wc_b - 1;
        if (reset || !busy_b) begin
            jx_b <= 0;
            if (reset) wc_b <= 0;
        end else if (xs_b) begin
            if (mask_b[jx_b]) wc_b <= dly_b;
            jx_b <= jx_b + 1;
        end
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // raise go at a negedge; g is the edge that samples it
    task automatic go_on_a(input logic [3:0] nj, output int g);
        @(negedge clk);
        go_a    = 1'b1;
        njobs_a = nj;
        g       = cyc + 1;
    endtask

    task automatic go_off_a();
        @(negedge clk);
        go_a = 1'b0;
    endtask

    initial begin
        int g;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset xs", int'(xs_a), 0);
        chk("reset busy", int'(busy_a), 0);
        chk("reset done", int'(done_a), 0);
        chk("reset err", int'(err_a), 0);
        chk("reset completed", int'(completed_a), 0);
        reset = 1'b0;

        // normal batch, 3 jobs, worker answers 3 cycles after xs; ignored go while busy and fin in GAP/IDLE
        mask_a = 8'hFF;
        dly_a  = 3;
        go_on_a(4'd3, g);
        qa.push_back(mk(0, g, 0, 0));
        qa.push_back(mk(0, g + 6, 1, 0));
        qa.push_back(mk(0, g + 12, 2, 0));
        qa.push_back(mk(1, g + 16, 3, 0));
        go_off_a();
        wait_until(g + 3);
        go_a    = 1'b1;
        njobs_a = 4'd1;
        @(negedge clk);
        go_a   = 1'b0;
        fin_ma = 1'b1;
        @(negedge clk);
        fin_ma = 1'b0;
        wait_until(g + 17);
        chk("batch busy after", int'(busy_a), 0);
        chk("batch completed after", int'(completed_a), 3);
        chk("batch err after", int'(err_a), 0);
        fin_ma = 1'b1;
        @(negedge clk);
        fin_ma = 1'b0;
        @(negedge clk);
        chk("idle fin completed", int'(completed_a), 3);
        chk("idle fin busy", int'(busy_a), 0);

        // timeout: 4 jobs, only job 1 answered
        mask_a = 8'h01;
        go_on_a(4'd4, g);
        qa.push_back(mk(0, g, 0, 0));
        qa.push_back(mk(0, g + 6, 1, 0));
        qa.push_back(mk(1, g + 23, 1, 1));
        go_off_a();
        wait_until(g + 30);
        chk("timeout err sticky", int'(err_a), 1);
        chk("timeout completed", int'(completed_a), 1);

        // njobs=0 after an errored batch: clears err/completed at accept, done with no xs
        go_on_a(4'd0, g);
        qa.push_back(mk(1, g, 0, 0));
        go_off_a();
        chk("accept clears err", int'(err_a), 0);
        chk("accept clears completed", int'(completed_a), 0);
        repeat (2) @(negedge clk);
        chk("zero-job busy after", int'(busy_a), 0);

        // fin on the exact expiry edge wins
        mask_a = 8'h00;
        go_on_a(4'd1, g);
        qa.push_back(mk(0, g, 0, 0));
        qa.push_back(mk(1, g + 17, 1, 0));
        go_off_a();
        wait_until(g + 16);
        fin_ma = 1'b1;
        @(negedge clk);
        fin_ma = 1'b0;
        wait_until(g + 20);

        // asynchronous reset in WAIT of job 2
        mask_a = 8'h01;
        go_on_a(4'd3, g);
        qa.push_back(mk(0, g, 0, 0));
        qa.push_back(mk(0, g + 6, 1, 0));
        go_off_a();
        wait_until(g + 9);
        #2 reset = 1'b1;
        #1;
        chk("async reset xs", int'(xs_a), 0);
        chk("async reset busy", int'(busy_a), 0);
        chk("async reset done", int'(done_a), 0);
        chk("async reset err", int'(err_a), 0);
        chk("async reset completed", int'(completed_a), 0);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        mask_a = 8'hFF;
        go_on_a(4'd2, g);
        qa.push_back(mk(0, g, 0, 0));
        qa.push_back(mk(0, g + 6, 1, 0));
        qa.push_back(mk(1, g + 10, 2, 0));
        go_off_a();
        wait_until(g + 12);

        // GAP=0 instance, immediate worker, 5 jobs
        mask_b = 8'hFF;
        dly_b  = 1;
        @(negedge clk);
        go_b    = 1'b1;
        njobs_b = 4'd5;
        g       = cyc + 1;
        for (int j = 0; j < 5; j++) qb.push_back(mk(0, g + 2 * j, j, 0));
        qb.push_back(mk(1, g + 10, 5, 0));
        @(negedge clk);
        go_b = 1'b0;
        wait_until(g + 13);
        chk("B busy after", int'(busy_b), 0);

        chk("A missing events", qa.size(), 0);
        chk("B missing events", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
